// File: rtl/traffic_pkg.sv
// Shared light codes, fault codes and monitor states for the traffic light monitor.
package traffic_pkg;

  typedef enum logic [2:0] {
    RED    = 3'b111,
    GREEN  = 3'b011,
    YELLOW = 3'b001
  } light_t;

  // Numeric order doubles as priority: lowest code wins when several faults coincide.
  typedef enum logic [2:0] {
    NONE      = 3'd0,
    INVALID   = 3'd1,
    CONFLICT  = 3'd2,
    ILLEGAL_A = 3'd3,
    ILLEGAL_B = 3'd4,
    GREEN_TO  = 3'd5,
    SYNC_TO   = 3'd6
  } fault_t;

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    MONITOR = 2'd1,
    FAULT   = 2'd2
  } mon_state_t;

  function automatic logic is_valid_light(input logic [2:0] code);
    return (code == RED) || (code == GREEN) || (code == YELLOW);
  endfunction

endpackage

// File: rtl/light_seq_checker.sv
// Per-approach sequence checker: remembers the previous light code and times how long
// the approach has been green, flagging bad codes, forbidden jumps and green overstay.
module light_seq_checker
  import traffic_pkg::*;
#(
  parameter int MAX_GREEN_TICKS = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic       run,
  input  logic       tick,
  input  logic [2:0] light,
  output logic       invalid,
  output logic       illegal_trans,
  output logic       green_timeout,
  output logic       enter_green
);

  localparam int GW = $clog2(MAX_GREEN_TICKS + 2);

  logic [2:0]    prev_reg;
  logic [GW-1:0] green_cnt_reg;
  logic          is_green;

  assign is_green      = (light == GREEN);
  assign invalid       = !is_valid_light(light);
  assign illegal_trans = ((prev_reg == GREEN) && (light == RED)) ||
                         ((prev_reg == RED) && (light == GREEN));
  // Flags the tick that would push the green count past the limit, so the
  // registered fault lands one clock after that sample.
  assign green_timeout = is_green && tick && (green_cnt_reg >= GW'(MAX_GREEN_TICKS));
  assign enter_green   = (prev_reg == YELLOW) && is_green;

  always_ff @(posedge clock) begin
    if (reset) begin
      prev_reg      <= RED;
      green_cnt_reg <= '0;
    end else if (load) begin
      prev_reg      <= light;
      green_cnt_reg <= '0;
    end else if (run) begin
      prev_reg <= light;
      if (!is_green)
        green_cnt_reg <= '0;
      else if (tick && (green_cnt_reg <= GW'(MAX_GREEN_TICKS)))
        green_cnt_reg <= green_cnt_reg + GW'(1);
    end
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Receiving-side checker for the controller's La/Lb light buses: locks onto the cycle
// start, then watches sequence, exclusion and green timing, latching the first fault.
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int MAX_GREEN_TICKS = 16,
  parameter int SYNC_TICKS      = 16,
  parameter int CNT_W           = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick,
  input  logic [2:0]       La,
  input  logic [2:0]       Lb,
  input  logic             clear_fault,
  output logic             fault,
  output logic [2:0]       fault_code,
  output logic             in_sync,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int SW = $clog2(SYNC_TICKS + 1);

  mon_state_t       state_reg;
  logic [SW-1:0]    sync_cnt_reg;
  logic             fault_reg;
  fault_t           fault_code_reg;
  logic             in_sync_reg;
  logic [CNT_W-1:0] cycle_count_reg;

  logic [1:0] invalid;
  logic [1:0] illegal;
  logic [1:0] green_to;
  logic [1:0] enter_green;
  logic       sync_match;
  logic       load;
  logic       run;
  fault_t     detected;
  logic       unused_enter_green_b;

  assign sync_match = (La == GREEN) && (Lb == RED);
  assign load       = (state_reg == SYNC) && sync_match;
  assign run        = (state_reg == MONITOR);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chk
      light_seq_checker #(
        .MAX_GREEN_TICKS(MAX_GREEN_TICKS)
      ) u_chk (
        .clock        (clock),
        .reset        (reset),
        .load         (load),
        .run          (run),
        .tick         (tick),
        .light        ((gi == 0) ? La : Lb),
        .invalid      (invalid[gi]),
        .illegal_trans(illegal[gi]),
        .green_timeout(green_to[gi]),
        .enter_green  (enter_green[gi])
      );
    end
  endgenerate

  // Only approach A's Y->G completes a counted cycle.
  assign unused_enter_green_b = enter_green[1];

  always_comb begin
    detected = NONE;
    if (|invalid)
      detected = INVALID;
    else if ((La != RED) && (Lb != RED))
      detected = CONFLICT;
    else if (illegal[0])
      detected = ILLEGAL_A;
    else if (illegal[1])
      detected = ILLEGAL_B;
    else if (|green_to)
      detected = GREEN_TO;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= SYNC;
      sync_cnt_reg    <= '0;
      fault_reg       <= 1'b0;
      fault_code_reg  <= NONE;
      in_sync_reg     <= 1'b0;
      cycle_count_reg <= '0;
    end else begin
      case (state_reg)
        SYNC: begin
          if (sync_match) begin
            state_reg    <= MONITOR;
            in_sync_reg  <= 1'b1;
            sync_cnt_reg <= '0;
          end else if (tick) begin
            if (sync_cnt_reg == SW'(SYNC_TICKS - 1)) begin
              state_reg      <= FAULT;
              fault_reg      <= 1'b1;
              fault_code_reg <= SYNC_TO;
              sync_cnt_reg   <= '0;
            end else begin
              sync_cnt_reg <= sync_cnt_reg + SW'(1);
            end
          end
        end
        MONITOR: begin
          if (detected != NONE) begin
            state_reg      <= FAULT;
            fault_reg      <= 1'b1;
            fault_code_reg <= detected;
            in_sync_reg    <= 1'b0;
          end else if (enter_green[0] && (cycle_count_reg != '1)) begin
            cycle_count_reg <= cycle_count_reg + CNT_W'(1);
          end
        end
        FAULT: begin
          if (clear_fault) begin
            state_reg      <= SYNC;
            fault_reg      <= 1'b0;
            fault_code_reg <= NONE;
          end
        end
        default: state_reg <= SYNC;
      endcase
    end
  end

  assign fault       = fault_reg;
  assign fault_code  = fault_code_reg;
  assign in_sync     = in_sync_reg;
  assign cycle_count = cycle_count_reg;

endmodule
